// File: rtl/beep_arbiter.sv
// beep_arbiter: fixed-priority preemptive buzzer sequencer (alarm > chime > key); ALARM_REPEAT_EN loops the alarm until alarm_ack.
// Latency: req pulse at edge k -> pending at k+1 -> beep_en at k+2; phase lengths are exact multiples of TICK_DIV cycles.
// Backpressure: none; a busy class drops repeat requests, lower classes wait as one pending request each, mute flushes everything.
module beep_arbiter #(
    parameter int TICK_DIV  = 50000,
    parameter int KEY_ON    = 50,
    parameter int CHIME_ON  = 100,
    parameter int CHIME_OFF = 100,
    parameter int ALARM_ON  = 300,
    parameter int ALARM_OFF = 200,
    parameter int ALARM_N   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_key,
    input  logic       req_chime,
    input  logic       req_alarm,
    input  logic       alarm_ack,
    input  logic       mute,
    input  logic       voice_1k,
    output logic       beep,
    output logic       busy,
    output logic [1:0] active,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    localparam logic [1:0]  CLS_NONE  = 2'd0;
    localparam logic [1:0]  CLS_KEY   = 2'd1;
    localparam logic [1:0]  CLS_CHIME = 2'd2;
    localparam logic [1:0]  CLS_ALARM = 2'd3;
    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    state_t      state;
    logic [2:0]  pending;
    logic        beep_en;
    logic [15:0] presc;
    logic [9:0]  ms_cnt;
    logic [2:0]  bcnt;

    logic [1:0]  pend_top;
    logic        take;
    logic [2:0]  grant_mask;
    logic        phase_end;
    logic        last_beep;
    logic [2:0]  next_bcnt;
    logic        rpt_cls;
    logic        ack_stop;

    function automatic logic [9:0] on_ms(input logic [1:0] c);
        case (c)
            CLS_KEY:   on_ms = 10'(KEY_ON);
            CLS_CHIME: on_ms = 10'(CHIME_ON);
            CLS_ALARM: on_ms = 10'(ALARM_ON);
            default:   on_ms = 10'd1;
        endcase
    endfunction

    function automatic logic [9:0] off_ms(input logic [1:0] c);
        case (c)
            CLS_CHIME: off_ms = 10'(CHIME_OFF);
            CLS_ALARM: off_ms = 10'(ALARM_OFF);
            default:   off_ms = 10'd0;
        endcase
    endfunction

    function automatic logic [2:0] n_beeps(input logic [1:0] c);
        case (c)
            CLS_CHIME: n_beeps = 3'd2;
            CLS_ALARM: n_beeps = 3'(ALARM_N);
            default:   n_beeps = 3'd1;
        endcase
    endfunction

    function automatic logic [2:0] cls_mask(input logic [1:0] c);
        case (c)
            CLS_KEY:   cls_mask = 3'b001;
            CLS_CHIME: cls_mask = 3'b010;
            CLS_ALARM: cls_mask = 3'b100;
            default:   cls_mask = 3'b000;
        endcase
    endfunction

`ifdef ALARM_REPEAT_EN
    assign rpt_cls  = (active == CLS_ALARM);
    assign ack_stop = alarm_ack && (active == CLS_ALARM) && (state != IDLE);
`else
    wire unused_alarm_ack = alarm_ack;
    assign rpt_cls  = 1'b0;
    assign ack_stop = 1'b0;
`endif

    always_comb begin
        pend_top = CLS_NONE;
        if (pending[2])      pend_top = CLS_ALARM;
        else if (pending[1]) pend_top = CLS_CHIME;
        else if (pending[0]) pend_top = CLS_KEY;
        // Idle grant and preemption share one path: the new class always enters ON directly.
        take       = (pending != 3'b000) && ((state == IDLE) || (pend_top > active));
        grant_mask = take ? cls_mask(pend_top) : 3'b000;
        phase_end  = (presc == 16'd0) && (ms_cnt == 10'd0);
        last_beep  = (bcnt == 3'd1);
        next_bcnt  = last_beep ? 3'(ALARM_N) : bcnt - 3'd1;
    end

    assign beep = beep_en & voice_1k;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 3'b000;
            beep_en <= 1'b0;
            active  <= CLS_NONE;
            done    <= 1'b0;
            presc   <= 16'd0;
            ms_cnt  <= 10'd0;
            bcnt    <= 3'd0;
        end else if (mute) begin
            state   <= IDLE;
            pending <= 3'b000;
            beep_en <= 1'b0;
            active  <= CLS_NONE;
            done    <= 1'b0;
            presc   <= 16'd0;
            ms_cnt  <= 10'd0;
            bcnt    <= 3'd0;
        end else begin
            done    <= 1'b0;
            pending <= (pending | ({req_alarm, req_chime, req_key} & ~cls_mask(active))) & ~grant_mask;
            if (take) begin
                state   <= ON;
                beep_en <= 1'b1;
                active  <= pend_top;
                presc   <= PRESC_MAX;
                ms_cnt  <= on_ms(pend_top) - 10'd1;
                bcnt    <= n_beeps(pend_top);
            end else if (ack_stop) begin
                state   <= IDLE;
                beep_en <= 1'b0;
                active  <= CLS_NONE;
                done    <= 1'b1;
            end else if (state != IDLE) begin
                if (!phase_end) begin
                    if (presc == 16'd0) begin
                        presc  <= PRESC_MAX;
                        ms_cnt <= ms_cnt - 10'd1;
                    end else begin
                        presc <= presc - 16'd1;
                    end
                end else if (state == OFF || (off_ms(active) == 10'd0 && (!last_beep || rpt_cls))) begin
                    // End of a gap, or a zero-length gap: straight into the next beep.
                    state   <= ON;
                    beep_en <= 1'b1;
                    presc   <= PRESC_MAX;
                    ms_cnt  <= on_ms(active) - 10'd1;
                    bcnt    <= next_bcnt;
                end else if (last_beep && !rpt_cls) begin
                    state   <= IDLE;
                    beep_en <= 1'b0;
                    active  <= CLS_NONE;
                    done    <= 1'b1;
                end else begin
                    state   <= OFF;
                    beep_en <= 1'b0;
                    presc   <= PRESC_MAX;
                    ms_cnt  <= off_ms(active) - 10'd1;
                end
            end
        end
    end

endmodule
